// File: rtl/spectrum_bank_ctrl_pkg.sv
// Shared types and helpers for the spectrum bank controller: bank index,
// write-FSM encoding and the saturating right-shift used by the scaler.
`default_nettype none

package spec_pkg;

  localparam int FFT_LEN_DEF   = 1024;
  localparam int STORE_LEN_DEF = 512;

  typedef logic [1:0] bank_t;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_WR     = 2'd1,
    ST_COMMIT = 2'd2
  } wr_state_t;

  // Caller truncates the result to its display width; maxv is that width's full scale.
  function automatic logic [31:0] sat_shift(input logic [31:0] d,
                                            input logic [4:0]  sh,
                                            input logic [31:0] maxv);
    logic [31:0] s;
    s = d >> sh;
    return (s > maxv) ? maxv : s;
  endfunction

endpackage

`default_nettype wire

// File: rtl/spectrum_bank_ctrl_if.sv
// FFT-side, display-side and status signals of the spectrum bank controller.
`default_nettype none

interface spectrum_bank_ctrl_if #(
  parameter int ADDR_W = 9,
  parameter int DIN_W  = 32,
  parameter int DOUT_W = 10
) ();

  logic              fft_valid;
  logic              fft_sop;
  logic              fft_eop;
  logic [DIN_W-1:0]  fft_data;
  logic [4:0]        scale_shift;
  logic              disp_frame_start;
  logic              rd_en;
  logic [ADDR_W-1:0] rd_addr;
  logic [DOUT_W-1:0] rd_data;
  logic              frame_ready;
  logic              frame_err;
  logic [15:0]       drop_cnt;

  modport master (
    output fft_valid, fft_sop, fft_eop, fft_data, scale_shift,
    output disp_frame_start, rd_en, rd_addr,
    input  rd_data, frame_ready, frame_err, drop_cnt
  );

  modport slave (
    input  fft_valid, fft_sop, fft_eop, fft_data, scale_shift,
    input  disp_frame_start, rd_en, rd_addr,
    output rd_data, frame_ready, frame_err, drop_cnt
  );

endinterface

`default_nettype wire

// File: rtl/spectrum_bank_ctrl_ram.sv
// Simple dual-port RAM backing the three spectrum banks; registered read port.
`default_nettype none

module spec_sdp_ram #(
  parameter int AW    = 11,
  parameter int DW    = 10,
  parameter int DEPTH = 1536
) (
  input  wire logic          clk,
  input  wire logic          i_we,
  input  wire logic [AW-1:0] i_waddr,
  input  wire logic [DW-1:0] i_wdata,
  input  wire logic          i_re,
  input  wire logic [AW-1:0] i_raddr,
  output logic      [DW-1:0] o_rdata
);

  logic [DW-1:0] r_mem [DEPTH];

  always_ff @(posedge clk) begin
    if (i_we) r_mem[i_waddr] <= i_wdata;
    if (i_re) o_rdata <= r_mem[i_raddr];
  end

endmodule

`default_nettype wire

// File: rtl/spectrum_bank_ctrl.sv
// Triple-buffered FFT magnitude store: scales and keeps the first half of each
// frame, and hands complete frames to the display without tearing.
`default_nettype none

module spectrum_bank_ctrl
  import spec_pkg::*;
#(
  parameter int FFT_LEN   = FFT_LEN_DEF,
  parameter int STORE_LEN = STORE_LEN_DEF,
  parameter int ADDR_W    = $clog2(STORE_LEN),
  parameter int DIN_W     = 32,
  parameter int DOUT_W    = 10
) (
  input wire logic           sys_clk,
  input wire logic           sys_rstn,
  spectrum_bank_ctrl_if.slave bus
);

  localparam int              CNT_W       = $clog2(FFT_LEN) + 1;
  localparam int              RAM_AW      = ADDR_W + 2;
  localparam logic [CNT_W-1:0] C_FFT_LEN   = CNT_W'(FFT_LEN);
  localparam logic [CNT_W-1:0] C_STORE_LEN = CNT_W'(STORE_LEN);
  localparam logic [31:0]     C_SAT_MAX   = 32'((1 << DOUT_W) - 1);

  // Input stage: sample flags and scaled magnitude, consumed by the FSM next cycle.
  logic              r_s_valid, r_s_sop, r_s_eop;
  logic [DOUT_W-1:0] r_s_data;

  always_ff @(posedge sys_clk or negedge sys_rstn) begin
    if (!sys_rstn) begin
      r_s_valid <= 1'b0;
      r_s_sop   <= 1'b0;
      r_s_eop   <= 1'b0;
      r_s_data  <= '0;
    end else begin
      r_s_valid <= bus.fft_valid;
      r_s_sop   <= bus.fft_valid & bus.fft_sop;
      r_s_eop   <= bus.fft_valid & bus.fft_eop;
      if (bus.fft_valid)
        r_s_data <= DOUT_W'(sat_shift(32'(bus.fft_data), bus.scale_shift, C_SAT_MAX));
    end
  end

  wr_state_t        r_state, w_state_nxt;
  logic [CNT_W-1:0] r_cnt, w_cnt_nxt, w_cnt_inc;
  logic             w_we, w_err, r_err;
  logic [ADDR_W-1:0] w_widx;

  assign w_cnt_inc = r_cnt + CNT_W'(1);

  always_ff @(posedge sys_clk or negedge sys_rstn) begin
    if (!sys_rstn) begin
      r_state <= ST_IDLE;
      r_cnt   <= '0;
      r_err   <= 1'b0;
    end else begin
      r_state <= w_state_nxt;
      r_cnt   <= w_cnt_nxt;
      r_err   <= w_err;
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      ST_IDLE, ST_COMMIT: begin
        w_state_nxt = ST_IDLE;
        if (r_s_sop) begin
          if (!r_s_eop)          w_state_nxt = ST_WR;
          else if (FFT_LEN == 1) w_state_nxt = ST_COMMIT;
        end
      end
      ST_WR: begin
        if (r_s_valid) begin
          if (r_s_sop) begin
            if (!r_s_eop)          w_state_nxt = ST_WR;
            else if (FFT_LEN == 1) w_state_nxt = ST_COMMIT;
            else                   w_state_nxt = ST_IDLE;
          end else if (r_s_eop) begin
            w_state_nxt = (w_cnt_inc == C_FFT_LEN) ? ST_COMMIT : ST_IDLE;
          end else if (w_cnt_inc == C_FFT_LEN) begin
            w_state_nxt = ST_IDLE;
          end
        end
      end
      default: w_state_nxt = ST_IDLE;
    endcase
  end

  always_comb begin
    w_we      = 1'b0;
    w_widx    = '0;
    w_cnt_nxt = r_cnt;
    w_err     = 1'b0;
    case (r_state)
      ST_IDLE, ST_COMMIT: begin
        if (r_s_sop) begin
          w_we      = 1'b1;
          w_cnt_nxt = CNT_W'(1);
          w_err     = r_s_eop && (FFT_LEN != 1);
        end
      end
      ST_WR: begin
        if (r_s_valid) begin
          if (r_s_sop) begin
            w_we      = 1'b1;
            w_cnt_nxt = CNT_W'(1);
            w_err     = 1'b1;
          end else begin
            w_we      = (r_cnt < C_STORE_LEN);
            w_widx    = r_cnt[ADDR_W-1:0];
            w_cnt_nxt = w_cnt_inc;
            w_err     = r_s_eop ? (w_cnt_inc != C_FFT_LEN) : (w_cnt_inc == C_FFT_LEN);
          end
        end
      end
      default: ;
    endcase
  end

  // Bank ownership: commit and display swap may land on the same edge.
  bank_t       r_bank_w, r_bank_r, r_bank_d;
  bank_t       w_bank_w_nxt, w_bank_r_nxt, w_bank_d_nxt;
  logic        r_pending, w_pending_nxt, w_drop_inc;
  logic [15:0] r_drop;
  logic        w_commit;

  assign w_commit = (r_state == ST_COMMIT);

  always_comb begin
    w_bank_w_nxt  = r_bank_w;
    w_bank_r_nxt  = r_bank_r;
    w_bank_d_nxt  = r_bank_d;
    w_pending_nxt = r_pending;
    w_drop_inc    = 1'b0;
    if (w_commit && bus.disp_frame_start && r_pending) begin
      w_bank_d_nxt = r_bank_r;
      w_bank_r_nxt = r_bank_w;
      w_bank_w_nxt = r_bank_d;
    end else if (w_commit) begin
      w_bank_w_nxt  = r_bank_r;
      w_bank_r_nxt  = r_bank_w;
      w_pending_nxt = 1'b1;
      w_drop_inc    = r_pending;
    end else if (bus.disp_frame_start && r_pending) begin
      w_bank_d_nxt  = r_bank_r;
      w_bank_r_nxt  = r_bank_d;
      w_pending_nxt = 1'b0;
    end
  end

  always_ff @(posedge sys_clk or negedge sys_rstn) begin
    if (!sys_rstn) begin
      r_bank_w  <= 2'd0;
      r_bank_r  <= 2'd1;
      r_bank_d  <= 2'd2;
      r_pending <= 1'b0;
      r_drop    <= '0;
    end else begin
      r_bank_w  <= w_bank_w_nxt;
      r_bank_r  <= w_bank_r_nxt;
      r_bank_d  <= w_bank_d_nxt;
      r_pending <= w_pending_nxt;
      if (w_drop_inc && (r_drop != 16'hFFFF)) r_drop <= r_drop + 16'd1;
    end
  end

  // A sample seen during COMMIT belongs to the next frame, so it targets the new W bank.
  bank_t             w_wbank;
  logic [RAM_AW-1:0] w_waddr, w_raddr;
  logic [DOUT_W-1:0] w_ram_q;
  logic              r_rd_zero;

  assign w_wbank = w_commit ? w_bank_w_nxt : r_bank_w;
  assign w_waddr = {w_wbank, w_widx};
  assign w_raddr = {r_bank_d, bus.rd_addr};

  spec_sdp_ram #(
    .AW    (RAM_AW),
    .DW    (DOUT_W),
    .DEPTH (3 * STORE_LEN)
  ) u_ram (
    .clk     (sys_clk),
    .i_we    (w_we),
    .i_waddr (w_waddr),
    .i_wdata (r_s_data),
    .i_re    (bus.rd_en),
    .i_raddr (w_raddr),
    .o_rdata (w_ram_q)
  );

  always_ff @(posedge sys_clk or negedge sys_rstn) begin
    if (!sys_rstn)     r_rd_zero <= 1'b1;
    else if (bus.rd_en) r_rd_zero <= ({1'b0, bus.rd_addr} >= (ADDR_W + 1)'(STORE_LEN));
  end

  assign bus.rd_data     = r_rd_zero ? '0 : w_ram_q;
  assign bus.frame_ready = r_pending;
  assign bus.frame_err   = r_err;
  assign bus.drop_cnt    = r_drop;

endmodule

`default_nettype wire
